rd_pipe_tracker: RTL and testbench

RD_PIPE_TRACKER -- requirements
Module: rd_pipe_tracker

---
 rtl/rd_pipe_tracker.sv | 93 +++++++++
 tb/tb_rd_pipe_tracker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rd_pipe_tracker.sv
// Destination-register tracker for a 5-stage pipeline: carries rd/RegWrite
// through EX, MEM and WB and raises a load-use stall for the ID stage.
module rd_pipe_tracker #(
  parameter logic [15:0] STALL_CNT_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rd,
  input  logic        id_regWrite,
  input  logic        id_memRead,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        flush,
  output logic [4:0]  RS_1,
  output logic [4:0]  RS_2,
  output logic [4:0]  rdEx,
  output logic [4:0]  rdMem,
  output logic [4:0]  rdWb,
  output logic        regWrite_Ex,
  output logic        regWrite_Mem,
  output logic        regWrite_Wb,
  output logic        memRead_Ex,
  output logic        stall,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_entry_t;

  // MEM and WB keep only the fields anything downstream can observe.
  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
  } late_entry_t;

  ex_entry_t   ex_q, ex_d;
  late_entry_t mem_q, wb_q;
  logic        rs1_hit, rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_q.rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_q.rd);
  assign stall   = ex_q.mem_read && (ex_q.rd != '0) && id_valid && (rs1_hit || rs2_hit);

  always_comb begin
    ex_d = '0;
    if (id_valid && !stall && !flush) begin
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_regWrite && (id_rd != '0);
      ex_d.mem_read  = id_memRead;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= '{rd: ex_q.rd, reg_write: ex_q.reg_write};
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != STALL_CNT_MAX)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign RS_1         = ex_q.rs1;
  assign RS_2         = ex_q.rs2;
  assign rdEx         = ex_q.rd;
  assign regWrite_Ex  = ex_q.reg_write;
  assign memRead_Ex   = ex_q.mem_read;
  assign rdMem        = mem_q.rd;
  assign regWrite_Mem = mem_q.reg_write;
  assign rdWb         = wb_q.rd;
  assign regWrite_Wb  = wb_q.reg_write;

endmodule

// File: tb/tb_rd_pipe_tracker.sv
// Table-driven bench for rd_pipe_tracker plus directed reset and
// stall-counter saturation sequences.
module tb_rd_pipe_tracker;

  localparam logic [15:0] SAT_MAX = 16'd40;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rd;
  logic        id_regWrite;
  logic        id_memRead;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        flush;
  logic [4:0]  RS_1, RS_2, rdEx, rdMem, rdWb;
  logic        regWrite_Ex, regWrite_Mem, regWrite_Wb, memRead_Ex, stall;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  rd_pipe_tracker #(.STALL_CNT_MAX(SAT_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_rd(id_rd), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .flush(flush),
    .RS_1(RS_1), .RS_2(RS_2), .rdEx(rdEx), .rdMem(rdMem), .rdWb(rdWb),
    .regWrite_Ex(regWrite_Ex), .regWrite_Mem(regWrite_Mem),
    .regWrite_Wb(regWrite_Wb), .memRead_Ex(memRead_Ex),
    .stall(stall), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       rw, mr;
    logic [4:0] rs1, rs2;
    logic       u1, u2, fl;
    logic       e_stall;
    logic [4:0] e_rd_ex;
    logic       e_rw_ex, e_mr_ex;
    logic [4:0] e_rs1, e_rs2, e_rd_mem;
    logic       e_rw_mem;
    logic [4:0] e_rd_wb;
    logic       e_rw_wb;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int v, int rd, int rw, int mr, int rs1, int rs2,
                              int u1, int u2, int fl, int st,
                              int erd, int erw, int emr, int ers1, int ers2,
                              int mrd, int mrw, int wrd, int wrw, int cnt);
    vec_t t;
    t.v = 1'(v);   t.rd = 5'(rd);   t.rw = 1'(rw);   t.mr = 1'(mr);
    t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.u1 = 1'(u1); t.u2 = 1'(u2);
    t.fl = 1'(fl); t.e_stall = 1'(st);
    t.e_rd_ex = 5'(erd); t.e_rw_ex = 1'(erw); t.e_mr_ex = 1'(emr);
    t.e_rs1 = 5'(ers1); t.e_rs2 = 5'(ers2);
    t.e_rd_mem = 5'(mrd); t.e_rw_mem = 1'(mrw);
    t.e_rd_wb = 5'(wrd); t.e_rw_wb = 1'(wrw);
    t.e_cnt = 16'(cnt);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic fl);
    id_valid = v; id_rd = rd; id_regWrite = rw; id_memRead = mr;
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2; flush = fl;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdEx"}, 16'(rdEx), 16'd0);
    chk({tag, "_rdMem"}, 16'(rdMem), 16'd0);
    chk({tag, "_rdWb"}, 16'(rdWb), 16'd0);
    chk({tag, "_rwEx"}, 16'(regWrite_Ex), 16'd0);
    chk({tag, "_rwMem"}, 16'(regWrite_Mem), 16'd0);
    chk({tag, "_rwWb"}, 16'(regWrite_Wb), 16'd0);
    chk({tag, "_mrEx"}, 16'(memRead_Ex), 16'd0);
    chk({tag, "_RS_1"}, 16'(RS_1), 16'd0);
    chk({tag, "_RS_2"}, 16'(RS_2), 16'd0);
    chk({tag, "_stall"}, 16'(stall), 16'd0);
    chk({tag, "_cnt"}, stall_count, 16'd0);
  endtask

  initial begin
    //        v rd rw mr r1 r2 u1 u2 fl | st exRd rw mr rs1 rs2 | mRd rw | wRd rw | cnt
    // add x5 then bubbles: rd walks EX -> MEM -> WB -> gone
    vecs.push_back(mk(1, 5,1,0, 1,2, 1,1,0,  0, 5,1,0, 1,2,  0,0,  0,0, 0));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0, 0,0,0, 0,0,  5,1,  0,0, 0));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0, 0,0,0, 0,0,  0,0,  5,1, 0));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0, 0,0,0, 0,0,  0,0,  0,0, 0));
    // lw x7 ; add x8,x7,x1 : one stall, then captured behind a bubble
    vecs.push_back(mk(1, 7,1,1, 2,0, 1,0,0,  0, 7,1,1, 2,0,  0,0,  0,0, 0));
    vecs.push_back(mk(1, 8,1,0, 7,1, 1,1,0,  1, 0,0,0, 0,0,  7,1,  0,0, 1));
    vecs.push_back(mk(1, 8,1,0, 7,1, 1,1,0,  0, 8,1,0, 7,1,  0,0,  7,1, 1));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0, 0,0,0, 0,0,  8,1,  0,0, 1));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0, 0,0,0, 0,0,  0,0,  8,1, 1));
    // lw x7 ; unrelated ; use of x7 : no stall
    vecs.push_back(mk(1, 7,1,1, 3,0, 1,0,0,  0, 7,1,1, 3,0,  0,0,  0,0, 1));
    vecs.push_back(mk(1,10,1,0, 1,2, 1,1,0,  0,10,1,0, 1,2,  7,1,  0,0, 1));
    vecs.push_back(mk(1,11,1,0, 7,7, 1,1,0,  0,11,1,0, 7,7, 10,1,  7,1, 1));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0, 0,0,0, 0,0, 11,1, 10,1, 1));
    // lw x0 ; use of x0 ; addi x0 with regWrite
    vecs.push_back(mk(1, 0,1,1, 4,0, 1,0,0,  0, 0,0,1, 4,0,  0,0, 11,1, 1));
    vecs.push_back(mk(1,12,1,0, 0,0, 1,1,0,  0,12,1,0, 0,0,  0,0,  0,0, 1));
    vecs.push_back(mk(1, 0,1,0, 1,0, 1,0,0,  0, 0,0,0, 1,0, 12,1,  0,0, 1));
    // flush kills add x9 while older entries advance
    vecs.push_back(mk(1, 9,1,0, 5,0, 1,0,1,  0, 0,0,0, 0,0,  0,0, 12,1, 1));
    // flush together with a stall: bubble and count
    vecs.push_back(mk(1, 6,1,1, 1,0, 1,0,0,  0, 6,1,1, 1,0,  0,0,  0,0, 1));
    vecs.push_back(mk(1,13,1,0, 6,0, 1,0,1,  1, 0,0,0, 0,0,  6,1,  0,0, 2));
    vecs.push_back(mk(0, 0,0,0, 0,0, 0,0,0,  0, 0,0,0, 0,0,  0,0,  6,1, 2));
    // matching sources that are not used never stall; rs2-only use does
    vecs.push_back(mk(1, 3,1,1, 2,0, 1,0,0,  0, 3,1,1, 2,0,  0,0,  0,0, 2));
    vecs.push_back(mk(1,14,1,0, 3,3, 0,0,0,  0,14,1,0, 3,3,  3,1,  0,0, 2));
    vecs.push_back(mk(1, 3,1,1, 2,0, 1,0,0,  0, 3,1,1, 2,0, 14,1,  3,1, 2));
    vecs.push_back(mk(1,15,1,0, 1,3, 1,1,0,  1, 0,0,0, 0,0,  3,1, 14,1, 3));
    vecs.push_back(mk(1,15,1,0, 1,3, 1,1,0,  0,15,1,0, 1,3,  0,0,  3,1, 3));
    // invalid ID slot never stalls
    vecs.push_back(mk(1, 3,1,1, 2,0, 1,0,0,  0, 3,1,1, 2,0, 15,1,  0,0, 3));
    vecs.push_back(mk(0,16,1,0, 3,0, 1,0,0,  0, 0,0,0, 0,0,  3,1, 15,1, 3));

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].rs1, vecs[i].rs2,
            vecs[i].u1, vecs[i].u2, vecs[i].fl);
      #1 chk($sformatf("v%0d_stall", i), 16'(stall), 16'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rdEx", i), 16'(rdEx), 16'(vecs[i].e_rd_ex));
      chk($sformatf("v%0d_rwEx", i), 16'(regWrite_Ex), 16'(vecs[i].e_rw_ex));
      chk($sformatf("v%0d_mrEx", i), 16'(memRead_Ex), 16'(vecs[i].e_mr_ex));
      chk($sformatf("v%0d_RS_1", i), 16'(RS_1), 16'(vecs[i].e_rs1));
      chk($sformatf("v%0d_RS_2", i), 16'(RS_2), 16'(vecs[i].e_rs2));
      chk($sformatf("v%0d_rdMem", i), 16'(rdMem), 16'(vecs[i].e_rd_mem));
      chk($sformatf("v%0d_rwMem", i), 16'(regWrite_Mem), 16'(vecs[i].e_rw_mem));
      chk($sformatf("v%0d_rdWb", i), 16'(rdWb), 16'(vecs[i].e_rd_wb));
      chk($sformatf("v%0d_rwWb", i), 16'(regWrite_Wb), 16'(vecs[i].e_rw_wb));
      chk($sformatf("v%0d_cnt", i), stall_count, vecs[i].e_cnt);
    end

    // Reset asserted mid-stall clears everything at once; first edge after release captures ID.
    drive(1, 7, 1, 1, 2, 0, 1, 0, 0);
    @(posedge clk);
    #1 drive(1, 8, 1, 0, 7, 1, 1, 1, 0);
    #1 chk("midrst_pre_stall", 16'(stall), 16'd1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("midrst");
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_rdEx", 16'(rdEx), 16'd8);
    chk("postrst_RS_1", 16'(RS_1), 16'd7);
    chk("postrst_mrEx", 16'(memRead_Ex), 16'd0);
    chk("postrst_stall", 16'(stall), 16'd0);
    chk("postrst_cnt", stall_count, 16'd0);

    // lw x7,0(x7) held in ID stalls on every other edge; counter must stop at its ceiling.
    drive(1, 7, 1, 1, 7, 0, 1, 0, 0);
    for (int i = 0; i < 300 && stall_count != SAT_MAX; i++) begin
      @(posedge clk);
      #1;
    end
    chk("sat_reach", stall_count, SAT_MAX);
    repeat (12) begin
      @(posedge clk);
      #1 chk("sat_hold", stall_count, SAT_MAX);
    end
    if (!stall) begin
      @(posedge clk);
      #1;
    end
    chk("sat_stall_active", 16'(stall), 16'd1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("sat_rst");
    #1 reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
